// File: rtl/packet_fifo_buffer.sv
// Single-clock sample FIFO between ADC capture and the USB engine: registered read data,
// packet-ready flag, sticky error flags and synchronous flush. Define PACKET_FIFO_HIGHWATER_EN for the highWater peak-fill port.
module packet_fifo_buffer #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned PACKET_WORDS = 8192,
    parameter int unsigned ERROR_MARGIN = 68
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  collectData,
    input  logic                  readData,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  dataAvailable,
    output logic [ADDR_WIDTH:0]   usedWords,
    output logic                  full,
    output logic                  empty,
    output logic                  bufferError,
`ifdef PACKET_FIFO_HIGHWATER_EN
    output logic [ADDR_WIDTH:0]   highWater,
`endif
    output logic                  underflowError
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] PACKET_C = CW'(PACKET_WORDS);
    // A margin larger than the FIFO makes every fill level count as near-full.
    localparam bit            NEAR_ALWAYS = ERROR_MARGIN > DEPTH;
    localparam logic [CW-1:0] NEAR_LIMIT  = NEAR_ALWAYS ? '0 : CW'(DEPTH - ERROR_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         used_q, used_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_q, valid_d;
    logic                  berr_q, berr_d;
    logic                  uerr_q, uerr_d;
    logic                  rd_en, wr_en, rd_fire, wr_fire, near_full, err_cond;
`ifdef PACKET_FIFO_HIGHWATER_EN
    logic [CW-1:0]         hw_q, hw_d;
`endif

    assign full          = (used_q == DEPTH_C);
    assign empty         = (used_q == '0);
    assign dataAvailable = (used_q >= PACKET_C);

    assign rd_en   = readData & ~empty;
    assign wr_en   = collectData & (~full | rd_en);
    assign rd_fire = rd_en & ~flush;
    assign wr_fire = wr_en & ~flush;

    assign near_full = NEAR_ALWAYS | (used_q > NEAR_LIMIT);
    assign err_cond  = collectData & ((full & ~rd_en) | near_full);

    // Next-state logic; flush overrides every request of the cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        valid_d  = 1'b0;
        berr_d   = err_cond | (collectData & berr_q);
        uerr_d   = uerr_q | (readData & empty);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
            berr_d   = 1'b0;
            uerr_d   = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            valid_d = rd_en;
            case ({wr_en, rd_en})
                2'b10:   used_d = used_q + CW'(1);
                2'b01:   used_d = used_q - CW'(1);
                default: used_d = used_q;
            endcase
        end
    end

`ifdef PACKET_FIFO_HIGHWATER_EN
    always_comb begin
        hw_d = (used_d > hw_q) ? used_d : hw_q;
        if (flush) hw_d = '0;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) hw_q <= '0;
        else         hw_q <= hw_d;
    end

    assign highWater = hw_q;
`endif

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            valid_q  <= 1'b0;
            berr_q   <= 1'b0;
            uerr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            valid_q  <= valid_d;
            berr_q   <= berr_d;
            uerr_q   <= uerr_d;
        end
    end

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_ptr_q] <= dataIn;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset)      data_out_q <= '0;
        else if (rd_fire) data_out_q <= mem[rd_ptr_q];
    end

    assign dataOut        = data_out_q;
    assign dataValid      = valid_q;
    assign usedWords      = used_q;
    assign bufferError    = berr_q;
    assign underflowError = uerr_q;

endmodule

// File: tb/tb_packet_fifo_buffer.sv
// Self-checking bench for packet_fifo_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model; a second instance uses a non-zero error margin.
module tb_packet_fifo_buffer;

    localparam int DW    = 10;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PKT   = 8;

    logic          clock = 1'b0;
    logic          nReset, collectData, readData, flush;
    logic [DW-1:0] dataIn;

    logic [DW-1:0] a_dout, b_dout;
    logic          a_valid, a_avail, a_full, a_empty, a_berr, a_uerr;
    logic          b_valid, b_avail, b_full, b_empty, b_berr, b_uerr;
    logic [AW:0]   a_used, b_used;
`ifdef PACKET_FIFO_HIGHWATER_EN
    logic [AW:0]   a_hw, b_hw;
`endif

    packet_fifo_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_WORDS(PKT), .ERROR_MARGIN(0)) dut_a (
        .clock(clock), .nReset(nReset), .collectData(collectData), .readData(readData),
        .flush(flush), .dataIn(dataIn), .dataOut(a_dout), .dataValid(a_valid),
        .dataAvailable(a_avail), .usedWords(a_used), .full(a_full), .empty(a_empty),
        .bufferError(a_berr),
`ifdef PACKET_FIFO_HIGHWATER_EN
        .highWater(a_hw),
`endif
        .underflowError(a_uerr));

    packet_fifo_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_WORDS(PKT), .ERROR_MARGIN(4)) dut_b (
        .clock(clock), .nReset(nReset), .collectData(collectData), .readData(readData),
        .flush(flush), .dataIn(dataIn), .dataOut(b_dout), .dataValid(b_valid),
        .dataAvailable(b_avail), .usedWords(b_used), .full(b_full), .empty(b_empty),
        .bufferError(b_berr),
`ifdef PACKET_FIFO_HIGHWATER_EN
        .highWater(b_hw),
`endif
        .underflowError(b_uerr));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of stored words plus the observable flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    bit            m_valid, m_berr0, m_berr4, m_uerr;
    int            m_hw;

    function automatic void m_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_berr0 = 1'b0;
        m_berr4 = 1'b0;
        m_uerr  = 1'b0;
        m_hw    = 0;
    endfunction

    function automatic void m_step(bit c, bit r, bit f, logic [DW-1:0] d);
        int used = mq.size();
        bit rdacc, wracc, is_full;
        if (f) begin
            mq.delete();
            m_valid = 1'b0;
            m_berr0 = 1'b0;
            m_berr4 = 1'b0;
            m_uerr  = 1'b0;
            m_hw    = 0;
            return;
        end
        is_full = (used == DEPTH);
        rdacc   = r && (used != 0);
        wracc   = c && (!is_full || rdacc);
        if (r && used == 0) m_uerr = 1'b1;
        m_berr0 = c && ((is_full && !rdacc) || used > DEPTH || m_berr0);
        m_berr4 = c && ((is_full && !rdacc) || used > DEPTH - 4 || m_berr4);
        m_valid = rdacc;
        if (rdacc) m_dout = mq.pop_front();
        if (wracc) mq.push_back(d);
        if (mq.size() > m_hw) m_hw = mq.size();
    endfunction

    task automatic tick(input bit c, input bit r, input bit f, input logic [DW-1:0] d);
        collectData = c;
        readData    = r;
        flush       = f;
        dataIn      = d;
        @(posedge clock);
        m_step(c, r, f, d);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] act, exp;
        collectData = 0; readData = 0; flush = 0; dataIn = '0;
        nReset = 1'b0;
        m_reset();
        #2;
        exp = {10'h000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        act = {a_dout, a_valid, a_avail, a_used, a_full, a_empty, a_berr, a_uerr};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", act, exp);
        end
        act = {b_dout, b_valid, b_avail, b_used, b_full, b_empty, b_berr, b_uerr};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", act, exp);
        end
        #6 nReset = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 5; i++) tick(1, 0, 0, DW'(i));
        for (int i = 1; i <= 5; i++) begin
            tick(0, 1, 0, '0);
            n_checks++;
            if (a_valid !== 1'b1 || a_dout !== DW'(i)) begin
                n_fail++;
                $display("FAIL basic_read%0d: got valid=%b data=%h expected valid=1 data=%h", i, a_valid, a_dout, DW'(i));
            end
        end
        tick(0, 0, 0, '0);
        n_checks++;
        if (a_empty !== 1'b1 || a_used !== 5'd0 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got empty=%b used=%0d valid=%b expected 1 0 0", a_empty, a_used, a_valid);
        end
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 7; i++) tick(1, 0, 0, DW'($urandom));
        n_checks++;
        if (a_avail !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_7: got avail=%b expected 0", a_avail);
        end
        tick(1, 0, 0, DW'($urandom));
        n_checks++;
        if (a_avail !== 1'b1 || a_used !== 5'd8) begin
            n_fail++;
            $display("FAIL thresh_8: got avail=%b used=%0d expected 1 8", a_avail, a_used);
        end
        tick(0, 1, 0, '0);
        n_checks++;
        if (a_avail !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_read: got avail=%b expected 0", a_avail);
        end
        tick(0, 0, 1, '0);
    endtask

    task automatic test_overflow();
        logic [DW-1:0] words [17];
        for (int i = 0; i < 17; i++) words[i] = DW'($urandom);
        for (int i = 0; i < 16; i++) tick(1, 0, 0, words[i]);
        n_checks++;
        if (a_full !== 1'b1 || a_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got full=%b berr=%b expected 1 0", a_full, a_berr);
        end
        tick(1, 0, 0, words[16]);
        n_checks++;
        if (a_berr !== 1'b1 || a_used !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_drop: got berr=%b used=%0d expected 1 16", a_berr, a_used);
        end
        tick(1, 0, 0, words[16]);
        n_checks++;
        if (a_berr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got berr=%b expected 1", a_berr);
        end
        tick(0, 0, 0, '0);
        n_checks++;
        if (a_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got berr=%b expected 0", a_berr);
        end
        for (int i = 0; i < 16; i++) begin
            tick(0, 1, 0, '0);
            n_checks++;
            if (a_valid !== 1'b1 || a_dout !== words[i]) begin
                n_fail++;
                $display("FAIL ovf_read%0d: got valid=%b data=%h expected 1 %h", i, a_valid, a_dout, words[i]);
            end
        end
    endtask

    task automatic test_full_concurrent();
        logic [DW-1:0] seq [20];
        for (int i = 0; i < 20; i++) seq[i] = DW'($urandom);
        for (int i = 0; i < 16; i++) tick(1, 0, 0, seq[i]);
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 0, seq[16+i]);
            n_checks++;
            if (a_used !== 5'd16 || a_full !== 1'b1 || a_berr !== 1'b0 || a_valid !== 1'b1 || a_dout !== seq[i]) begin
                n_fail++;
                $display("FAIL full_rw%0d: got used=%0d full=%b berr=%b valid=%b data=%h expected 16 1 0 1 %h",
                         i, a_used, a_full, a_berr, a_valid, a_dout, seq[i]);
            end
        end
        for (int i = 4; i < 20; i++) begin
            tick(0, 1, 0, '0);
            n_checks++;
            if (a_valid !== 1'b1 || a_dout !== seq[i]) begin
                n_fail++;
                $display("FAIL full_drain%0d: got valid=%b data=%h expected 1 %h", i, a_valid, a_dout, seq[i]);
            end
        end
    endtask

    task automatic test_underflow_flush();
        logic [DW-1:0] held;
        held = a_dout;
        tick(0, 1, 0, '0);
        n_checks++;
        if (a_valid !== 1'b0 || a_uerr !== 1'b1 || a_dout !== held) begin
            n_fail++;
            $display("FAIL underflow: got valid=%b uerr=%b data=%h expected 0 1 %h", a_valid, a_uerr, a_dout, held);
        end
        for (int i = 0; i < 3; i++) tick(1, 0, 0, DW'($urandom));
        tick(1, 1, 1, 10'h155);
        n_checks++;
        if (a_used !== 5'd0 || a_uerr !== 1'b0 || a_valid !== 1'b0 || a_dout !== held) begin
            n_fail++;
            $display("FAIL flush: got used=%0d uerr=%b valid=%b data=%h expected 0 0 0 %h", a_used, a_uerr, a_valid, a_dout, held);
        end
        tick(0, 1, 0, '0);
        n_checks++;
        if (a_valid !== 1'b0 || a_used !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_read: got valid=%b used=%0d expected 0 0", a_valid, a_used);
        end
        tick(0, 0, 1, '0);
    endtask

    task automatic test_near_full();
        for (int i = 0; i < 13; i++) tick(1, 0, 0, DW'($urandom));
        n_checks++;
        if (b_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL near_13: got berr=%b expected 0", b_berr);
        end
        tick(1, 0, 0, DW'($urandom));
        n_checks++;
        if (b_berr !== 1'b1 || a_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL near_14: got margin4 berr=%b margin0 berr=%b expected 1 0", b_berr, a_berr);
        end
        tick(0, 0, 0, '0);
        n_checks++;
        if (b_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL near_clear: got berr=%b expected 0", b_berr);
        end
        tick(0, 0, 1, '0);
    endtask

    task automatic test_async_reset();
        logic [20:0] act, exp;
        for (int i = 0; i < 10; i++) tick(1, 0, 0, DW'($urandom));
        tick(0, 1, 0, '0);
        collectData = 0; readData = 0; flush = 0;
        #2 nReset = 1'b0;
        #1;
        m_reset();
        exp = {10'h000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        act = {a_dout, a_valid, a_avail, a_used, a_full, a_empty, a_berr, a_uerr};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", act, exp);
        end
        #1 nReset = 1'b1;
        tick(1, 0, 0, 10'h3FF);
        tick(0, 1, 0, '0);
        n_checks++;
        if (a_valid !== 1'b1 || a_dout !== 10'h3FF || a_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_roundtrip: got valid=%b data=%h empty=%b expected 1 3ff 1", a_valid, a_dout, a_empty);
        end
    endtask

    task automatic test_random();
        logic [20:0] act, exp;
        logic [16:0] actb, expb;
        int pc, pr;
        for (int i = 0; i < 600; i++) begin
            case ((i / 50) % 3)
                0:       begin pc = 85; pr = 20; end
                1:       begin pc = 20; pr = 85; end
                default: begin pc = 60; pr = 60; end
            endcase
            tick($urandom_range(99) < pc, $urandom_range(99) < pr, $urandom_range(63) == 0, DW'($urandom));
            exp = {m_dout, m_valid, mq.size() >= PKT, 5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_berr0, m_uerr};
            act = {a_dout, a_valid, a_avail, a_used, a_full, a_empty, a_berr, a_uerr};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random_a cycle %0d: got %h expected %h", i, act, exp);
            end
            expb = {m_dout, m_valid, 5'(mq.size()), m_berr4};
            actb = {b_dout, b_valid, b_used, b_berr};
            n_checks++;
            if (actb !== expb) begin
                n_fail++;
                $display("FAIL random_b cycle %0d: got %h expected %h", i, actb, expb);
            end
`ifdef PACKET_FIFO_HIGHWATER_EN
            n_checks++;
            if (a_hw !== 5'(m_hw) || b_hw !== 5'(m_hw)) begin
                n_fail++;
                $display("FAIL highwater cycle %0d: got %0d/%0d expected %0d", i, a_hw, b_hw, m_hw);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_overflow();
        test_full_concurrent();
        test_underflow_flush();
        test_near_full();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
